// File: rtl/bpd_update_pkg.sv
// Shared branch-predictor update bundle: field widths, bit offsets inside the
// packed word (LSB first) and the matching packed struct.
package bpd_update_pkg;

    localparam int PC_W      = 40;
    localparam int BR_MASK_W = 4;
    localparam int CFI_IDX_W = 2;
    localparam int GHIST_W   = 64;
    localparam int RAS_IDX_W = 5;
    localparam int META_W    = 125;

    localparam int IS_MISPREDICT_OFF  = 0;
    localparam int IS_REPAIR_OFF      = IS_MISPREDICT_OFF + 1;
    localparam int PC_OFF             = IS_REPAIR_OFF + 1;
    localparam int BR_MASK_OFF        = PC_OFF + PC_W;
    localparam int CFI_IDX_VALID_OFF  = BR_MASK_OFF + BR_MASK_W;
    localparam int CFI_IDX_BITS_OFF   = CFI_IDX_VALID_OFF + 1;
    localparam int CFI_TAKEN_OFF      = CFI_IDX_BITS_OFF + CFI_IDX_W;
    localparam int CFI_MISPRED_OFF    = CFI_TAKEN_OFF + 1;
    localparam int CFI_IS_BR_OFF      = CFI_MISPRED_OFF + 1;
    localparam int CFI_IS_JAL_OFF     = CFI_IS_BR_OFF + 1;
    localparam int GHIST_OLD_OFF      = CFI_IS_JAL_OFF + 1;
    localparam int GHIST_CUR_NT_OFF   = GHIST_OLD_OFF + GHIST_W;
    localparam int GHIST_NEW_NT_OFF   = GHIST_CUR_NT_OFF + 1;
    localparam int GHIST_NEW_T_OFF    = GHIST_NEW_NT_OFF + 1;
    localparam int GHIST_RAS_IDX_OFF  = GHIST_NEW_T_OFF + 1;
    localparam int LHIST_0_OFF        = GHIST_RAS_IDX_OFF + RAS_IDX_W;
    localparam int TARGET_OFF         = LHIST_0_OFF + 1;
    localparam int META_0_OFF         = TARGET_OFF + PC_W;

    // Declared MSB first so that field offsets above match the packed layout.
    typedef struct packed {
        logic [META_W-1:0]    meta_0;
        logic [PC_W-1:0]      target;
        logic                 lhist_0;
        logic [RAS_IDX_W-1:0] ghist_ras_idx;
        logic                 ghist_new_saw_branch_taken;
        logic                 ghist_new_saw_branch_not_taken;
        logic                 ghist_current_saw_branch_not_taken;
        logic [GHIST_W-1:0]   ghist_old_history;
        logic                 cfi_is_jal;
        logic                 cfi_is_br;
        logic                 cfi_mispredicted;
        logic                 cfi_taken;
        logic [CFI_IDX_W-1:0] cfi_idx_bits;
        logic                 cfi_idx_valid;
        logic [BR_MASK_W-1:0] br_mask;
        logic [PC_W-1:0]      pc;
        logic                 is_repair_update;
        logic                 is_mispredict_update;
    } bpd_update_t;

    localparam int UPD_W = $bits(bpd_update_t);

endpackage

// File: rtl/bpd_update_fork_if.sv
// Handshake bundle of the update fork: merged input stream, two output ports,
// flush and occupancy. slave = the fork itself, master = its environment.
interface bpd_update_fork_if #(
    parameter int UPD_W = bpd_update_pkg::UPD_W,
    parameter int CNT_W = 3
);
    logic             io_in_valid;
    logic             io_in_ready;
    logic [UPD_W-1:0] io_in_bits;
    logic             io_in_chosen;
    logic             io_flush;
    logic             io_out_0_valid;
    logic             io_out_0_ready;
    logic [UPD_W-1:0] io_out_0_bits;
    logic             io_out_1_valid;
    logic             io_out_1_ready;
    logic [UPD_W-1:0] io_out_1_bits;
    logic             io_out_chosen;
    logic [CNT_W-1:0] io_count;

    modport slave (
        input  io_in_valid, io_in_bits, io_in_chosen, io_flush,
               io_out_0_ready, io_out_1_ready,
        output io_in_ready, io_out_0_valid, io_out_0_bits,
               io_out_1_valid, io_out_1_bits, io_out_chosen, io_count
    );

    modport master (
        output io_in_valid, io_in_bits, io_in_chosen, io_flush,
               io_out_0_ready, io_out_1_ready,
        input  io_in_ready, io_out_0_valid, io_out_0_bits,
               io_out_1_valid, io_out_1_bits, io_out_chosen, io_count
    );
endinterface

// File: rtl/bpd_update_fifo_ram.sv
// Simple dual-port storage with registered read; a same-cycle write to the
// address being read is forwarded so a fresh head is visible one cycle later.
module bpd_update_fifo_ram #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 292
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata_reg;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata_reg <= (we && (waddr == raddr)) ? wdata : mem[raddr];
    end

    assign rdata = rdata_reg;
endmodule

// File: rtl/bpd_update_fork.sv
// Buffers merged predictor updates and forks each head to two consumers;
// repair updates go only to port 0, and the head pops once every port is done.
module bpd_update_fork #(
    parameter int DEPTH = 4,
    parameter int UPD_W = bpd_update_pkg::UPD_W
) (
    input logic              clock,
    input logic              reset,
    bpd_update_fork_if.slave io
);
    import bpd_update_pkg::*;

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [1:0]       sent_reg, sent_next, sent_hold;
    logic [1:0]       sent_eff, ready, valid, fire;
    logic [UPD_W:0]   ram_rdata;
    logic             empty, head_repair, push, pop, in_ready;

    assign empty       = (cnt_reg == '0);
    assign head_repair = ram_rdata[IS_REPAIR_OFF];
    assign in_ready    = (cnt_reg < CNT_W'(DEPTH)) & ~io.io_flush;
    assign push        = io.io_in_valid & in_ready;
    assign ready       = {io.io_out_1_ready, io.io_out_0_ready};
    // A repair head is never offered on port 1, so it counts as delivered there.
    assign sent_eff    = {sent_reg[1] | head_repair, sent_reg[0]};

    for (genvar gi = 0; gi < 2; gi++) begin : g_port
        assign valid[gi]     = ~empty & ~sent_eff[gi];
        assign fire[gi]      = valid[gi] & ready[gi];
        assign sent_hold[gi] = sent_reg[gi] | fire[gi];
    end

    assign pop = ~empty & (&(sent_eff | fire));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            cnt_reg    <= '0;
            sent_reg   <= '0;
        end else begin
            rd_ptr_reg <= rd_ptr_next;
            wr_ptr_reg <= wr_ptr_next;
            cnt_reg    <= cnt_next;
            sent_reg   <= sent_next;
        end
    end

    always_comb begin
        rd_ptr_next = rd_ptr_reg;
        wr_ptr_next = wr_ptr_reg;
        cnt_next    = cnt_reg;
        sent_next   = sent_reg;
        if (io.io_flush) begin
            rd_ptr_next = '0;
            wr_ptr_next = '0;
            cnt_next    = '0;
            sent_next   = '0;
        end else begin
            cnt_next = cnt_reg + CNT_W'(push) - CNT_W'(pop);
            if (push) begin
                wr_ptr_next = wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_next = rd_ptr_reg + PTR_W'(1);
                sent_next   = '0;
            end else begin
                sent_next   = sent_hold;
            end
        end
    end

    // Read address is the next head so the registered read lines up with it.
    bpd_update_fifo_ram #(
        .DEPTH (DEPTH),
        .WIDTH (UPD_W + 1)
    ) u_ram (
        .clk   (clock),
        .we    (push),
        .waddr (wr_ptr_reg),
        .wdata ({io.io_in_chosen, io.io_in_bits}),
        .raddr (rd_ptr_next),
        .rdata (ram_rdata)
    );

    assign io.io_in_ready    = in_ready;
    assign io.io_out_0_valid = valid[0];
    assign io.io_out_1_valid = valid[1];
    assign io.io_out_0_bits  = empty ? '0 : ram_rdata[UPD_W-1:0];
    assign io.io_out_1_bits  = empty ? '0 : ram_rdata[UPD_W-1:0];
    assign io.io_out_chosen  = empty ? 1'b0 : ram_rdata[UPD_W];
    assign io.io_count       = cnt_reg;
endmodule

// File: tb/tb_bpd_update_fork.sv
// Directed scenarios followed by random traffic, checked every cycle against a
// queue-based model of the update fork.
module tb_bpd_update_fork;
    import bpd_update_pkg::*;

    localparam int DEPTH = 4;
    localparam int W     = UPD_W;
    localparam int CW    = $clog2(DEPTH) + 1;

    typedef logic [W:0] ent_t;  // {chosen, bits}

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    bpd_update_fork_if #(.UPD_W(W), .CNT_W(CW)) io ();

    bpd_update_fork #(.DEPTH(DEPTH), .UPD_W(W)) dut (
        .clock (clock),
        .reset (reset),
        .io    (io)
    );

    ent_t q[$];
    bit   s0, s1;
    int   compared   = 0;
    int   mismatched = 0;

    task automatic chk(input string tag, input ent_t obs, input ent_t exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    function automatic logic [W-1:0] mk_upd(input bit repair, input logic [PC_W-1:0] pc);
        logic [W-1:0] u;
        u = '0;
        for (int i = 0; i < (W + 31) / 32; i++) u = (u << 32) | W'($urandom);
        u[IS_REPAIR_OFF]   = repair;
        u[PC_OFF +: PC_W]  = pc;
        return u;
    endfunction

    task automatic check_outputs();
        ent_t hd;
        bit   emp, rep;
        emp = (q.size() == 0);
        hd  = emp ? '0 : q[0];
        rep = !emp && hd[IS_REPAIR_OFF];
        chk("in_ready",   ent_t'(io.io_in_ready),    ent_t'(q.size() < DEPTH && !io.io_flush));
        chk("out0_valid", ent_t'(io.io_out_0_valid), ent_t'(!emp && !s0));
        chk("out1_valid", ent_t'(io.io_out_1_valid), ent_t'(!emp && !s1 && !rep));
        chk("count",      ent_t'(io.io_count),       ent_t'(q.size()));
        chk("out0_bits",  ent_t'(io.io_out_0_bits),  ent_t'(hd[W-1:0]));
        chk("out1_bits",  ent_t'(io.io_out_1_bits),  ent_t'(hd[W-1:0]));
        chk("chosen",     ent_t'(io.io_out_chosen),  ent_t'(hd[W]));
    endtask

    // Check at the falling edge, advance the model, then cross the rising edge.
    task automatic cycle();
        bit emp, rep, v0, v1, f0, f1, rdy;
        @(negedge clock);
        check_outputs();
        emp = (q.size() == 0);
        rep = !emp && q[0][IS_REPAIR_OFF];
        v0  = !emp && !s0;
        v1  = !emp && !s1 && !rep;
        f0  = v0 && io.io_out_0_ready;
        f1  = v1 && io.io_out_1_ready;
        rdy = (q.size() < DEPTH) && !io.io_flush;
        if (io.io_flush) begin
            q.delete();
            s0 = 0;
            s1 = 0;
        end else begin
            if (!emp && (s0 || f0) && (s1 || rep || f1)) begin
                $display("pop  chosen=%0d pc=%h", q[0][W], q[0][PC_OFF +: PC_W]);
                void'(q.pop_front());
                s0 = 0;
                s1 = 0;
            end else begin
                s0 = s0 || f0;
                s1 = s1 || f1;
            end
            if (io.io_in_valid && rdy) begin
                $display("push chosen=%0d pc=%h repair=%0d", io.io_in_chosen,
                         io.io_in_bits[PC_OFF +: PC_W], io.io_in_bits[IS_REPAIR_OFF]);
                q.push_back({io.io_in_chosen, io.io_in_bits});
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic push_one(input bit repair, input logic [PC_W-1:0] pc, input bit ch);
        io.io_in_valid  = 1'b1;
        io.io_in_bits   = mk_upd(repair, pc);
        io.io_in_chosen = ch;
        cycle();
        io.io_in_valid  = 1'b0;
    endtask

    task automatic set_ready(input bit r0, input bit r1);
        io.io_out_0_ready = r0;
        io.io_out_1_ready = r1;
    endtask

    initial begin
        io.io_in_valid  = 1'b0;
        io.io_in_bits   = '0;
        io.io_in_chosen = 1'b0;
        io.io_flush     = 1'b0;
        set_ready(1'b0, 1'b0);
        s0 = 0;
        s1 = 0;

        // Reset state
        #3;
        check_outputs();
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;

        // Single non-repair update, both consumers ready
        set_ready(1'b1, 1'b1);
        push_one(1'b0, 40'h0080000000, 1'b1);
        repeat (3) cycle();

        // Repair update goes to port 0 only
        push_one(1'b1, PC_W'($urandom), 1'b0);
        repeat (3) cycle();

        // Port 1 stalls for three cycles after port 0 has taken the head
        set_ready(1'b1, 1'b0);
        push_one(1'b0, PC_W'($urandom), 1'b1);
        repeat (3) cycle();
        set_ready(1'b1, 1'b1);
        repeat (2) cycle();

        // Fill past capacity with outputs stalled, then drain across the wrap
        set_ready(1'b0, 1'b0);
        io.io_in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            io.io_in_bits   = mk_upd(i == 2, PC_W'(32'h1000 + i));
            io.io_in_chosen = i[0];
            cycle();
        end
        io.io_in_valid = 1'b0;
        @(negedge clock);
        chk("full_count", ent_t'(io.io_count), ent_t'(DEPTH));
        @(posedge clock);
        #1;
        set_ready(1'b1, 1'b1);
        repeat (8) cycle();

        // Flush with three buffered and a concurrent valid input
        set_ready(1'b0, 1'b0);
        io.io_in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            io.io_in_bits   = mk_upd(1'b0, PC_W'($urandom));
            io.io_in_chosen = 1'b1;
            cycle();
        end
        io.io_flush = 1'b1;
        cycle();
        io.io_flush    = 1'b0;
        io.io_in_valid = 1'b0;
        set_ready(1'b1, 1'b1);
        repeat (2) cycle();

        // Asynchronous reset while the head is half delivered
        set_ready(1'b1, 1'b0);
        push_one(1'b0, PC_W'($urandom), 1'b1);
        cycle();
        #2;
        reset = 1'b0;
        #1;
        chk("rst_out0_valid", ent_t'(io.io_out_0_valid), ent_t'(0));
        chk("rst_out1_valid", ent_t'(io.io_out_1_valid), ent_t'(0));
        chk("rst_count",      ent_t'(io.io_count),       ent_t'(0));
        chk("rst_in_ready",   ent_t'(io.io_in_ready),    ent_t'(1));
        q.delete();
        s0 = 0;
        s1 = 0;
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            io.io_in_valid  = ($urandom_range(0, 9) < 6);
            io.io_in_bits   = mk_upd($urandom_range(0, 9) < 3, PC_W'($urandom));
            io.io_in_chosen = 1'($urandom_range(0, 1));
            io.io_flush     = ($urandom_range(0, 31) == 0);
            set_ready($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7);
            cycle();
        end
        io.io_in_valid = 1'b0;
        io.io_flush    = 1'b0;
        set_ready(1'b1, 1'b1);
        repeat (6) cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/bpd_update_fork.md
BPD_UPDATE_FORK -- requirements
Module: bpd_update_fork

Interface
REQ-001 SHALL have parameter DEPTH, default 4, power of two ≥2, sets the number of FIFO entries.
REQ-002 SHALL have parameter UPD_W, default 291, sets the packed update-bundle width (layout defined in package).
REQ-003 SHALL have ports:
- clock  input  1  sole clock, rising edge.
- reset  input  1  asynchronous, active-low (0 = reset asserted).
- io_in_valid  input  1  merged update stream valid (arbiter output side).
- io_in_ready  output  1  block can accept an update.
- io_in_bits  input  UPD_W  packed update bundle.
- io_in_chosen  input  1  source index from upstream arbiter (0 = mispredict/repair path, 1 = commit path).
- io_flush  input  1  synchronous discard of all buffered updates.
- io_out_0_valid / io_out_0_ready / io_out_0_bits  out/in/out  1/1/UPD_W  port 0, all updates.
- io_out_1_valid / io_out_1_ready / io_out_1_bits  out/in/out  1/1/UPD_W  port 1, non-repair updates only.
- io_out_chosen  output  1  chosen tag of current head.
- io_count  output  log2(DEPTH)+1  occupied entries.

Function
REQ-004 SHALL store accepted updates, with chosen tag, in a DEPTH-entry circular FIFO; enqueue on io_in_valid & io_in_ready.
REQ-005 SHALL drive io_in_ready = (count < DEPTH) & ~io_flush; no same-cycle enqueue into a full FIFO even if the head pops.
REQ-006 SHALL present the head to both out ports; latency enqueue→out valid is exactly 1 cycle; no combinational in→out path.
REQ-007 SHALL keep per-head flags sent0/sent1; io_out_k_valid = ~empty & ~sent_k; sent_k set on io_out_k_valid & io_out_k_ready.
REQ-008 SHALL, when head is_repair_update bit = 1, treat sent1 as already set (io_out_1_valid = 0 for that entry).
REQ-009 SHALL pop the head in the cycle the last outstanding port handshakes (both may fire same cycle); pop clears sent0/sent1.
REQ-010 SHALL hold io_out_k_bits and io_out_chosen stable while the head is not popped.
REQ-011 SHALL wrap read/write pointers modulo DEPTH; simultaneous enqueue and pop leaves count unchanged.
REQ-012 SHALL, on io_flush = 1, in the next state set count = 0, pointers = 0, sent flags = 0, ignoring any handshake that cycle.
REQ-013 SHALL drive io_out_k_bits = 0 and io_out_chosen = 0 when empty.

Reset
REQ-014 SHALL on reset = 0 asynchronously clear pointers, count, sent0, sent1; outputs: io_in_ready = 1, out valids = 0, io_count = 0, bits = 0.
REQ-015 SHALL discard an in-progress partially-delivered head on reset; storage array need not be reset.

Structure
REQ-016 SHALL take UPD_W, the field-offset constants (is_mispredict_update, is_repair_update, pc, br_mask, cfi_*, ghist_*, lhist_0, target, meta_0) and the update typedef from shared package bpd_update_pkg.
REQ-017 SHALL instantiate one sub-module, bpd_update_fifo_ram (DEPTH × (UPD_W+1) storage, 1 write / 1 read port); fork logic stays in top.

Verification
REQ-018 Reset, then one update (pc=0x80000000, repair=0), both readies high → both valids at cycle +1, single pop, count 1→0.
REQ-019 Repair update (repair=1), out_1_ready high → out_1_valid stays 0, out_0 handshake alone pops it.
REQ-020 out_0_ready=1, out_1_ready=0 for 3 cycles then 1 → out_0 fires once only, sent0 held, pop on cycle out_1 fires, bits unchanged throughout.
REQ-021 Push 5 updates, outputs stalled, DEPTH=4 → io_in_ready=0 after 4th, count=4; release → order preserved across pointer wrap.
REQ-022 Count=3, io_flush=1 with io_in_valid=1 → count=0, no enqueue, out valids 0 next cycle.
REQ-023 reset to 0 mid-delivery (sent0=1) → out valids 0 immediately, count=0, io_in_ready=1.
